// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hh:mm:ss editor that commits the edited time via a valid/ready load
// Ports: clk, rst (sync, active-high); btn_mode/btn_inc/btn_dec debounced levels;
//    cur_hr/cur_min/cur_sec running time in; set_hr/set_min/set_sec edited time out;
//    load_valid/load_ready commit handshake; edit_field 0 none, 1 hr, 2 min, 3 sec; blink phase.
// Option: define AUTO_REPEAT_EN for auto-repeat of held inc/dec.
module time_set_ctrl #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned TIMEOUT_S    = 30,
   parameter int unsigned BLINK_DIV    = 4,
   parameter int unsigned RPT_DELAY_MS = 500,
   parameter int unsigned RPT_RATE_MS  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [5:0] cur_sec,
   input  logic [5:0] cur_min,
   input  logic [4:0] cur_hr,
   output logic [5:0] set_sec,
   output logic [5:0] set_min,
   output logic [4:0] set_hr,
   output logic       load_valid,
   input  logic       load_ready,
   output logic [1:0] edit_field,
   output logic       blink
);
   localparam logic [63:0] TO_CYC = 64'(TIMEOUT_S) * 64'(CLK_HZ);
   localparam int TO_W = $clog2(TO_CYC + 64'd1);
   localparam int unsigned BL_CYC = CLK_HZ / BLINK_DIV;
   localparam int BL_W = $clog2(BL_CYC + 1);
   typedef enum logic [2:0] {S_IDLE, S_HR, S_MIN, S_SEC, S_COMMIT} state_t;
   state_t r_state, w_next;
   logic [2:0] r_lvl, r_pls;
   logic [4:0] r_hr;
   logic [5:0] r_min, r_sec;
   logic [TO_W-1:0] r_to;
   logic [BL_W-1:0] r_bcnt;
   logic r_boff;
   logic w_mode, w_up, w_dn, w_step, w_any, w_edit, w_to;
   logic w_rpt_inc, w_rpt_dec;
   function automatic logic [5:0] f_step(input logic [5:0] v, input logic [5:0] top, input logic up);
      return up ? ((v == top) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? top : v - 6'd1);
   endfunction
   // {mode, inc, dec}: level history and registered rising-edge pulses
   always_ff @(posedge clk)
      if (rst) begin
         r_lvl <= '0;
         r_pls <= '0;
      end else begin
         r_lvl <= {btn_mode, btn_inc, btn_dec};
         r_pls <= {btn_mode, btn_inc, btn_dec} & ~r_lvl;
      end
`ifdef AUTO_REPEAT_EN
   localparam int unsigned RD = CLK_HZ / 1000 * RPT_DELAY_MS;
   localparam int unsigned RR = CLK_HZ / 1000 * RPT_RATE_MS;
   localparam int RW = $clog2(RD + 1);
   logic [RW-1:0] r_rc_inc, r_rc_dec;
   // counter equals held-cycle index; after a repeat it jumps back so the next fires RR cycles later
   assign w_rpt_inc = r_lvl[1] & (r_rc_inc == RW'(RD - 1));
   assign w_rpt_dec = r_lvl[0] & (r_rc_dec == RW'(RD - 1));
   always_ff @(posedge clk)
      if (rst || !w_edit || w_mode || !r_lvl[1]) r_rc_inc <= '0;
      else r_rc_inc <= w_rpt_inc ? RW'(RD - RR) : r_rc_inc + 1'b1;
   always_ff @(posedge clk)
      if (rst || !w_edit || w_mode || !r_lvl[0]) r_rc_dec <= '0;
      else r_rc_dec <= w_rpt_dec ? RW'(RD - RR) : r_rc_dec + 1'b1;
`else
   logic [31:0] w_unused_rpt;
   assign w_unused_rpt = RPT_DELAY_MS ^ RPT_RATE_MS;
   assign w_rpt_inc = 1'b0;
   assign w_rpt_dec = 1'b0;
`endif
   assign w_mode = r_pls[2];
   assign w_up   = r_pls[1] | w_rpt_inc;
   assign w_dn   = r_pls[0] | w_rpt_dec;
   assign w_edit = r_state inside {S_HR, S_MIN, S_SEC};
   assign w_any  = (|r_pls) | w_rpt_inc | w_rpt_dec;
   assign w_step = w_edit & ~w_mode & (w_up ^ w_dn);
   assign w_to   = w_edit & ~w_any & (r_to == TO_W'(TO_CYC - 64'd1));
   always_ff @(posedge clk)
      r_state <= rst ? S_IDLE : w_next;
   always_comb begin
      w_next     = r_state;
      edit_field = 2'd0;
      load_valid = 1'b0;
      case (r_state)
         S_IDLE:   w_next = w_mode ? S_HR : S_IDLE;
         S_HR: begin
            edit_field = 2'd1;
            w_next     = w_to ? S_IDLE : w_mode ? S_MIN : S_HR;
         end
         S_MIN: begin
            edit_field = 2'd2;
            w_next     = w_to ? S_IDLE : w_mode ? S_SEC : S_MIN;
         end
         S_SEC: begin
            edit_field = 2'd3;
            w_next     = w_to ? S_IDLE : w_mode ? S_COMMIT : S_SEC;
         end
         S_COMMIT: begin
            load_valid = 1'b1;
            w_next     = load_ready ? S_IDLE : S_COMMIT;
         end
         default:  w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_hr  <= '0;
         r_min <= '0;
         r_sec <= '0;
      end else if (r_state == S_IDLE && w_mode) begin
         r_hr  <= cur_hr;
         r_min <= cur_min;
         r_sec <= cur_sec;
      end else if (w_step) begin
         if (r_state == S_HR)  r_hr  <= 5'(f_step({1'b0, r_hr}, 6'd23, w_up));
         if (r_state == S_MIN) r_min <= f_step(r_min, 6'd59, w_up);
         if (r_state == S_SEC) r_sec <= f_step(r_sec, 6'd59, w_up);
      end
   // inactivity counter: any pulse or repeat step restarts it
   always_ff @(posedge clk)
      if (rst || !w_edit || w_any) r_to <= '0;
      else r_to <= r_to + 1'b1;
   // restart the divider on every state change so each field opens with blink=1
   always_ff @(posedge clk)
      if (rst || !w_edit || w_next != r_state) begin
         r_bcnt <= '0;
         r_boff <= 1'b0;
      end else if (r_bcnt == BL_W'(BL_CYC - 1)) begin
         r_bcnt <= '0;
         r_boff <= ~r_boff;
      end else r_bcnt <= r_bcnt + 1'b1;
   assign blink   = w_edit & ~r_boff;
   assign set_hr  = r_hr;
   assign set_min = r_min;
   assign set_sec = r_sec;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench with a cycle-level reference model of the time-set editor
module tb_time_set_ctrl;
   localparam int CLK_HZ = 1000;
   localparam int TOS    = 1;
   localparam int TO     = CLK_HZ * TOS;
   localparam int BL     = CLK_HZ / 4;
   localparam int RPT_D  = 50;
   localparam int RPT_R  = 20;
   localparam int HOLD   = RPT_D + 3 * RPT_R;
   localparam logic [2:0] BM = 3'b100, BI = 3'b010, BD = 3'b001;
   logic clk = 1'b0, rst = 1'b1;
   logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, load_ready = 1'b0;
   logic [5:0] cur_sec = 6'd56, cur_min = 6'd34;
   logic [4:0] cur_hr = 5'd12;
   logic [5:0] set_sec, set_min;
   logic [4:0] set_hr;
   logic load_valid, blink;
   logic [1:0] edit_field;
   int n_chk = 0, n_fail = 0;
   int m_f, m_age, m_quiet, m_hi, m_hd;
   int m_v[4];
   logic [2:0] m_lvp, m_pend;
   bit m_on = 0;
   time_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TOS), .BLINK_DIV(4),
      .RPT_DELAY_MS(RPT_D), .RPT_RATE_MS(RPT_R)) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
      .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr),
      .load_valid(load_valid), .load_ready(load_ready),
      .edit_field(edit_field), .blink(blink));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // spec-level model: field index 0 idle, 1..3 hr/min/sec, 4 commit
   task automatic model();
      bit mode, inc, dec, ri, rd, up, dn, any;
      int nf, md;
      if (rst) begin
         m_f = 0; m_age = 0; m_quiet = 0; m_hi = 0; m_hd = 0;
         m_v = '{0, 0, 0, 0};
         m_lvp = '0; m_pend = '0; m_on = 1;
         return;
      end
      mode = m_pend[2]; inc = m_pend[1]; dec = m_pend[0];
      ri = 0; rd = 0;
`ifdef AUTO_REPEAT_EN
      if (m_f >= 1 && m_f <= 3 && !mode && m_lvp[1]) begin
         ri = m_hi >= RPT_D - 1 && (m_hi - (RPT_D - 1)) % RPT_R == 0; m_hi++;
      end else m_hi = 0;
      if (m_f >= 1 && m_f <= 3 && !mode && m_lvp[0]) begin
         rd = m_hd >= RPT_D - 1 && (m_hd - (RPT_D - 1)) % RPT_R == 0; m_hd++;
      end else m_hd = 0;
`endif
      up = inc | ri; dn = dec | rd; any = mode | inc | dec | ri | rd;
      nf = m_f;
      if (m_f == 0) begin
         m_quiet = 0;
         if (mode) begin
            m_v[1] = cur_hr; m_v[2] = cur_min; m_v[3] = cur_sec; nf = 1;
         end
      end else if (m_f <= 3) begin
         md = (m_f == 1) ? 24 : 60;
         if (!mode && up != dn) m_v[m_f] = up ? (m_v[m_f] + 1) % md : (m_v[m_f] + md - 1) % md;
         m_quiet = any ? 0 : m_quiet + 1;
         if (m_quiet == TO) nf = 0;
         else if (mode) nf = m_f + 1;
      end else begin
         m_quiet = 0;
         if (load_ready) nf = 0;
      end
      m_age = (nf != m_f) ? 0 : m_age + 1;
      m_f = nf;
      m_pend = {btn_mode, btn_inc, btn_dec} & ~m_lvp;
      m_lvp = {btn_mode, btn_inc, btn_dec};
   endtask
   task automatic compare();
      int ef;
      ef = (m_f >= 1 && m_f <= 3) ? m_f : 0;
      chk("edit_field", edit_field, ef);
      chk("load_valid", load_valid, m_f == 4);
      chk("set_hr", set_hr, m_v[1]);
      chk("set_min", set_min, m_v[2]);
      chk("set_sec", set_sec, m_v[3]);
      chk("blink", blink, ef != 0 && (m_age / BL) % 2 == 0);
   endtask
   task automatic cyc();
      @(posedge clk);
      model();
      @(negedge clk);
      if (m_on) compare();
      #2;
   endtask
   task automatic btn(input logic [2:0] b);
      {btn_mode, btn_inc, btn_dec} = b;
      cyc();
      {btn_mode, btn_inc, btn_dec} = 3'b000;
      repeat (3) cyc();
   endtask
   initial begin
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_field", edit_field, 0);
      chk("rst_valid", load_valid, 0);
      chk("rst_set", {set_hr, set_min, set_sec}, 0);
      chk("rst_blink", blink, 0);
      btn(BM);
      chk("snap_field", edit_field, 1);
      chk("snap_set", {set_hr, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
      chk("snap_blink", blink, 1);
      repeat (11) btn(BI);
      chk("hr_23", set_hr, 23);
      btn(BI);
      chk("hr_wrap_up", set_hr, 0);
      btn(BD);
      chk("hr_wrap_dn", set_hr, 23);
      btn(BM);
      chk("min_field", edit_field, 2);
      repeat (34) btn(BD);
      chk("min_0", set_min, 0);
      btn(BD);
      chk("min_wrap_dn", set_min, 59);
      btn(BM);
      repeat (3) btn(BI);
      chk("sec_59", set_sec, 59);
      btn(BI);
      chk("sec_wrap_up", set_sec, 0);
      btn(BM);
      chk("commit_valid", load_valid, 1);
      repeat (5) begin
         cyc();
         chk("commit_hold", {load_valid, set_hr, set_min, set_sec}, {1'b1, 5'd23, 6'd59, 6'd0});
      end
      load_ready = 1'b1;
      cyc();
      chk("accept_valid", load_valid, 0);
      chk("accept_field", edit_field, 0);
      load_ready = 1'b0;
      btn(BM);
      chk("resnap", {set_hr, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
      btn(BI | BD);
      chk("inc_dec_same", set_hr, 12);
      btn(BM | BI);
      chk("mode_inc_field", edit_field, 2);
      chk("mode_inc_val", {set_hr, set_min}, {5'd12, 6'd34});
      repeat (TO - 10) cyc();
      chk("pre_timeout", edit_field, 2);
      repeat (20) cyc();
      chk("timeout_field", edit_field, 0);
      chk("timeout_set", {set_hr, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
      repeat (4) btn(BM);
      chk("commit2_valid", load_valid, 1);
      rst = 1'b1;
      cyc();
      chk("rst_commit_valid", load_valid, 0);
      chk("rst_commit_field", edit_field, 0);
      rst = 1'b0;
      cyc();
      btn(BM);
      btn_inc = 1'b1;
      repeat (HOLD) cyc();
      btn_inc = 1'b0;
      repeat (3) cyc();
`ifdef AUTO_REPEAT_EN
      chk("hold_inc", set_hr, 17);
`else
      chk("hold_inc", set_hr, 13);
`endif
      load_ready = 1'b1;
      repeat (3) btn(BM);
      chk("ready_early", {load_valid, edit_field}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
